// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch producer: PC, memory requests, branch redirect, freeze
// Optional perf counters stall_cycles/fetch_count enabled by defining FETCH_PERF_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        fetch_stall,
  output logic [31:0] stall_cycles,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_buf, instr_buf_d;
  logic [31:0] pc_buf, pc_buf_d;
  logic        redirect_pending, redirect_pending_d;
  logic [31:0] redirect_target, redirect_target_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_REQ;
      pc_q             <= RESET_PC;
      instr_buf        <= 32'h0;
      pc_buf           <= 32'h0;
      redirect_pending <= 1'b0;
      redirect_target  <= 32'h0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      instr_buf        <= instr_buf_d;
      pc_buf           <= pc_buf_d;
      redirect_pending <= redirect_pending_d;
      redirect_target  <= redirect_target_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    instr_buf_d        = instr_buf;
    pc_buf_d           = pc_buf;
    redirect_pending_d = redirect_pending;
    redirect_target_d  = redirect_target;
    case (state_q)
      S_REQ: begin
        state_d = S_WAIT;
        if (branch_taken) begin
          redirect_pending_d = 1'b1;
          redirect_target_d  = branch_addr;
        end
      end
      S_WAIT: begin
        // The access always completes; a redirect only decides whether its data is kept.
        if (mem_ready) begin
          state_d = S_REQ;
          if (branch_taken) begin
            pc_d               = branch_addr;
            redirect_pending_d = 1'b0;
          end else if (redirect_pending) begin
            pc_d               = redirect_target;
            redirect_pending_d = 1'b0;
          end else begin
            instr_buf_d = mem_rdata;
            pc_buf_d    = pc_q + 32'd4;
            state_d     = S_VALID;
          end
        end else if (branch_taken) begin
          redirect_pending_d = 1'b1;
          redirect_target_d  = branch_addr;
        end
      end
      S_VALID: begin
        if (branch_taken) begin
          pc_d    = branch_addr;
          state_d = S_REQ;
        end else if (!freeze) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign mem_req     = (state_q != S_VALID);
  assign mem_addr    = pc_q;
  assign fetch_stall = (state_q != S_VALID);
  assign PC          = (state_q == S_VALID) ? pc_buf : 32'h0;
  assign instruction = (state_q == S_VALID) ? instr_buf : 32'h0;

`ifdef FETCH_PERF_EN
  logic        accept;
  logic [31:0] stall_q, count_q;

  assign accept = (state_q == S_WAIT) && mem_ready && !branch_taken && !redirect_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      if (fetch_stall) stall_q <= stall_q + 32'd1;
      if (accept)      count_q <= count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign fetch_count  = count_q;
`else
  assign stall_cycles = 32'h0;
  assign fetch_count  = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit
// Expected deliveries are queued when memory data is driven and popped in S_VALID.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        fetch_stall;
  logic [31:0] stall_cycles;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] saved_count;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .PC           (PC),
    .instruction  (instruction),
    .fetch_stall  (fetch_stall),
    .stall_cycles (stall_cycles),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in S_REQ; leaves the DUT in S_VALID with the delivery checked.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int waits);
    exp_t e;
    n_vec++;
    if (mem_req !== 1'b1 || mem_addr !== addr || fetch_stall !== 1'b1 || PC !== 32'h0 || instruction !== 32'h0) begin
      n_err++;
      $display("FAIL req_phase: req=%b addr=%h stall=%b PC=%h instr=%h, required req=1 addr=%h stall=1 PC=0 instr=0",
               mem_req, mem_addr, fetch_stall, PC, instruction, addr);
    end
    step();
    for (int i = 0; i < waits; i++) begin
      n_vec++;
      if (mem_req !== 1'b1 || mem_addr !== addr || fetch_stall !== 1'b1) begin
        n_err++;
        $display("FAIL wait_phase: req=%b addr=%h stall=%b, required req=1 addr=%h stall=1", mem_req, mem_addr, fetch_stall, addr);
      end
      step();
    end
    mem_ready = 1'b1;
    mem_rdata = data;
    e.pc = addr + 32'd4;
    e.instr = data;
    sb.push_back(e);
    step();
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: size=0, required >=1");
    end else begin
      e = sb.pop_front();
      if (PC !== e.pc || instruction !== e.instr || fetch_stall !== 1'b0 || mem_req !== 1'b0) begin
        n_err++;
        $display("FAIL valid_phase: PC=%h instr=%h stall=%b req=%b, required PC=%h instr=%h stall=0 req=0",
                 PC, instruction, fetch_stall, mem_req, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_vec++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || PC !== 32'h0 || instruction !== 32'h0 || fetch_stall !== 1'b1
        || stall_cycles !== 32'h0 || fetch_count !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: req=%b addr=%h PC=%h instr=%h stall=%b sc=%0d fc=%0d, required 1 0 0 0 1 0 0",
               mem_req, mem_addr, PC, instruction, fetch_stall, stall_cycles, fetch_count);
    end
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    do_fetch(32'h0, 32'hE3A0_0001, 0);
    n_vec++;
`ifdef FETCH_PERF_EN
    if (stall_cycles !== 32'd2 || fetch_count !== 32'd1) begin
`else
    if (stall_cycles !== 32'd0 || fetch_count !== 32'd0) begin
`endif
      n_err++;
      $display("FAIL perf_first: sc=%0d fc=%0d", stall_cycles, fetch_count);
    end
    step();
    do_fetch(32'h4, 32'hE3A0_1002, 0);
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (PC !== 32'h8 || instruction !== 32'hE3A0_1002 || mem_req !== 1'b0 || fetch_stall !== 1'b0) begin
        n_err++;
        $display("FAIL freeze_hold: PC=%h instr=%h req=%b stall=%b, required PC=8 instr=e3a01002 req=0 stall=0",
                 PC, instruction, mem_req, fetch_stall);
      end
    end
    freeze = 1'b0;
    step();
    do_fetch(32'h8, 32'hE080_2001, 2);
  endtask

  task automatic test_branch_valid();
    branch_taken = 1'b1;
    branch_addr = 32'h100;
    freeze = 1'b1;
    step();
    branch_taken = 1'b0;
    freeze = 1'b0;
    do_fetch(32'h100, 32'h1111_0100, 0);
  endtask

  task automatic test_branch_wait();
    saved_count = fetch_count;
    step();
    step();
    branch_taken = 1'b1;
    branch_addr = 32'h200;
    step();
    branch_taken = 1'b0;
    step();
    step();
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ready = 1'b0;
    n_vec++;
    if (mem_addr !== 32'h200 || fetch_stall !== 1'b1 || instruction !== 32'h0 || fetch_count !== saved_count) begin
      n_err++;
      $display("FAIL redirect_drop: addr=%h stall=%b instr=%h fc=%0d, required addr=200 stall=1 instr=0 fc=%0d",
               mem_addr, fetch_stall, instruction, fetch_count, saved_count);
    end
    do_fetch(32'h200, 32'h2222_0200, 1);
    n_vec++;
`ifdef FETCH_PERF_EN
    if (fetch_count !== saved_count + 32'd1) begin
`else
    if (fetch_count !== 32'd0) begin
`endif
      n_err++;
      $display("FAIL perf_count: fc=%0d saved=%0d", fetch_count, saved_count);
    end
  endtask

  task automatic test_latest_wins();
    step();
    branch_taken = 1'b1;
    branch_addr = 32'h300;
    step();
    branch_addr = 32'h340;
    step();
    branch_taken = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0_0BAD;
    step();
    mem_ready = 1'b0;
    do_fetch(32'h340, 32'h3333_0340, 0);
    step();
    step();
    branch_taken = 1'b1;
    branch_addr = 32'h400;
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD1_1BAD;
    step();
    branch_taken = 1'b0;
    mem_ready = 1'b0;
    do_fetch(32'h400, 32'h4444_0400, 0);
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1;
    branch_addr = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    do_fetch(32'hFFFF_FFFC, 32'h5555_FFFC, 0);
    step();
    do_fetch(32'h0, 32'h6666_0000, 0);
  endtask

  task automatic test_async_reset();
    step();
    step();
    branch_taken = 1'b1;
    branch_addr = 32'h500;
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || PC !== 32'h0 || instruction !== 32'h0 || fetch_stall !== 1'b1
        || stall_cycles !== 32'h0 || fetch_count !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: req=%b addr=%h PC=%h instr=%h stall=%b sc=%0d fc=%0d, required 1 0 0 0 1 0 0",
               mem_req, mem_addr, PC, instruction, fetch_stall, stall_cycles, fetch_count);
    end
    branch_taken = 1'b0;
    step();
    rst = 1'b0;
    do_fetch(32'h0, 32'h7777_0000, 1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_freeze();
    test_branch_valid();
    test_branch_wait();
    test_latest_wins();
    test_wrap();
    test_async_reset();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: size=%0d, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch producer for the ARM pipeline. Owns the program counter and issues requests to instruction memory. It presents PC (fetched address + 4) and instruction to the IF/ID pipeline register. It also honours freeze from the hazard unit and branch redirects from EXE, and reports memory wait states upstream via fetch_stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
PC_STEP, 4, byte increment between sequential fetches.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
freeze  input  1  hazard stall; hold the current fetched instruction and PC
branch_taken  input  1  one-cycle pulse from EXE; redirect fetch
branch_addr  input  32  redirect target, sampled when branch_taken=1
mem_req  output  1  instruction memory request
mem_addr  output  32  instruction memory byte address
mem_rdata  input  32  instruction memory read data, valid when mem_ready=1
mem_ready  input  1  memory completion strobe
PC  output  32  address of delivered instruction + 4; drives IF/ID PC_in
instruction  output  32  delivered instruction; drives IF/ID instruction_in
fetch_stall  output  1  1 while no valid instruction is presented
stall_cycles  output  32  perf counter (see Optional Feature)
fetch_count  output  32  perf counter (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset state: pc_q=RESET_PC, state=S_REQ, buffers=0, redirect_pending=0, counters=0.
- Output values at reset: mem_req=1, mem_addr=RESET_PC, PC=0, instruction=0, fetch_stall=1.
- Registered state: pc_q[31:0], instr_buf[31:0], pc_buf[31:0], redirect_pending, redirect_target[31:0], 2-bit state.
- S_REQ (address phase):
  - Drives mem_req=1, mem_addr=pc_q.
  - mem_ready is ignored in this state.
  - Next state is S_WAIT unconditionally.
- S_WAIT:
  - mem_req=1; mem_addr=pc_q, held stable.
  - On mem_ready=1 with redirect_pending=0: instr_buf<=mem_rdata, pc_buf<=pc_q+4, go to S_VALID.
  - On mem_ready=1 with redirect_pending=1: discard data, pc_q<=redirect_target, clear redirect_pending, go to S_REQ.
- S_VALID:
  - mem_req=0, instruction=instr_buf, PC=pc_buf, fetch_stall=0.
  - branch_taken=1: pc_q<=branch_addr, go to S_REQ. This has priority over freeze.
  - Else freeze=1: hold everything; outputs stay stable indefinitely.
  - Else: pc_q<=pc_q+PC_STEP (32-bit wrap, no overflow flag), go to S_REQ.
- In S_REQ and S_WAIT: PC=0, instruction=0 (bubble), fetch_stall=1.
- Throughput and latency:
  - Minimum 3 cycles per instruction: REQ, WAIT with mem_ready, VALID.
  - Each extra memory wait cycle adds 1.
- Branch during an outstanding fetch (S_REQ or S_WAIT, including the cycle mem_ready=1):
  - Set redirect_pending=1 and redirect_target=branch_addr.
  - The in-flight memory access completes and its data is dropped. Requests are never aborted mid-access.
  - If branch_taken arrives in the S_WAIT cycle with mem_ready=1, the target is used directly: pc_q<=branch_addr, go to S_REQ.
  - A second branch_taken while pending overwrites redirect_target (latest wins).
- freeze in S_REQ/S_WAIT has no effect; fetch proceeds.
- branch_addr is not alignment-checked; low 2 bits are passed through to mem_addr.
- rst mid-operation: immediate return to reset values; an outstanding memory access is abandoned.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined:
  - stall_cycles increments every cycle fetch_stall=1.
  - fetch_count increments on each instruction accepted into S_VALID. Dropped redirect data is not counted.
  - Both are 32-bit, wrap at 2^32, and clear on rst.
- Undefined: both ports tied to 32'h0; no counter flops are instantiated.

Test Plan:
1. Reset release, mem_ready one cycle after each mem_req, freeze=0, RESET_PC=0 -> mem_addr sequence 0,4,8. instruction=mem_rdata and PC=4,8,12 in each S_VALID cycle. fetch_stall pattern 1,1,0 repeating.
2. In S_VALID (PC=8), assert freeze for 5 cycles -> PC=8 and instruction stable for 5 cycles, mem_req=0. The next fetch is addr 8 after freeze drops.
3. In S_VALID, assert branch_taken=1, branch_addr=32'h100, with freeze=1 -> next mem_addr=32'h100; freeze is ignored.
4. Branch to 32'h200 in S_WAIT, with mem_ready arriving 3 cycles later carrying 32'hDEADBEEF -> DEADBEEF is never presented. The next mem_addr is 32'h200. With FETCH_PERF_EN defined, fetch_count does not increment for the dropped data.
5. Assert rst asynchronously in S_WAIT -> outputs return to reset values without a clock edge, and mem_addr=RESET_PC.
6. pc_q=32'hFFFF_FFFC, sequential advance -> next mem_addr=32'h0, and PC output for that instruction=32'h0000_0000.
